// File: rtl/scalar_mul_ram_loader.sv
// Host-side loader for a RAM-mapped scalar-multiply engine: streams operand words into
// RAM, kicks the engine through a command word, polls status, then streams results back.
module scalar_mul_ram_loader #(
  parameter int Data      = 256,
  parameter int Addr      = 5,
  parameter int Beat      = 32,
  parameter int CMD_ADDR  = 62,
  parameter int STAT_ADDR = 63
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [Addr:0]   n_in,
  input  logic [Addr:0]   res_base,
  input  logic [Addr:0]   n_out,
  input  logic [Beat-1:0] in_data,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [Beat-1:0] out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            busy,
  output logic            done,
  output logic            a_w,
  output logic [Addr:0]   a_adbus,
  output logic [Data-1:0] a_data_in,
  input  logic [Data-1:0] a_data_out
);

  localparam int Beats = Data / Beat;
  localparam int BW    = (Beats > 1) ? $clog2(Beats) : 1;

  localparam logic [Addr:0]   CMD_A     = CMD_ADDR[Addr:0];
  localparam logic [Addr:0]   STAT_A    = STAT_ADDR[Addr:0];
  localparam logic [Addr:0]   WORD_ONE  = 1;
  localparam logic [BW-1:0]   BEAT_ONE  = 1;
  localparam logic [BW-1:0]   LAST_BEAT = BW'(Beats - 1);

  typedef enum logic [3:0] {
    IDLE, LOAD, WR, CMD, POLL_A, POLL_D, RD_A, RD_D, STREAM, CLR
  } state_t;

  state_t        state, state_d;
  logic [Addr:0] n_in_q, n_out_q, res_base_q;
  logic [Addr:0] word_cnt, rd_cnt;
  logic [Addr:0] word_cnt_inc, rd_cnt_inc;
  logic [BW-1:0] beat_cnt;
  logic [Data-1:0] asm_q, shift_q;

  assign word_cnt_inc = word_cnt + WORD_ONE;
  assign rd_cnt_inc   = rd_cnt + WORD_ONE;
  assign out_data     = shift_q[Beat-1:0];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = (state != IDLE);
    done      = 1'b0;
    a_w       = 1'b0;
    a_adbus   = '0;
    a_data_in = '0;
    case (state)
      IDLE: begin
        if (start) state_d = (n_in == '0) ? CMD : LOAD;
      end
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid && (beat_cnt == LAST_BEAT)) state_d = WR;
      end
      WR: begin
        a_w       = 1'b1;
        a_adbus   = word_cnt;
        a_data_in = asm_q;
        state_d   = (word_cnt_inc == n_in_q) ? CMD : LOAD;
      end
      CMD: begin
        a_w       = 1'b1;
        a_adbus   = CMD_A;
        a_data_in = {{(Data-1){1'b0}}, 1'b1};
        state_d   = POLL_A;
      end
      POLL_A: begin
        a_adbus = STAT_A;
        state_d = POLL_D;
      end
      POLL_D: begin
        // Status read data belongs to the address presented in POLL_A
        if (a_data_out[0]) state_d = (n_out_q == '0) ? CLR : RD_A;
        else               state_d = POLL_A;
      end
      RD_A: begin
        a_adbus = res_base_q + rd_cnt;
        state_d = RD_D;
      end
      RD_D: begin
        state_d = STREAM;
      end
      STREAM: begin
        out_valid = 1'b1;
        if (out_ready && (beat_cnt == LAST_BEAT))
          state_d = (rd_cnt_inc == n_out_q) ? CLR : RD_A;
      end
      CLR: begin
        a_w       = 1'b1;
        a_adbus   = CMD_A;
        a_data_in = '0;
        done      = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand beats shift in from the top so beat k ends up at bits k*Beat once the word is full
  always_ff @(posedge clk) begin
    if (rst) begin
      n_in_q     <= '0;
      n_out_q    <= '0;
      res_base_q <= '0;
      word_cnt   <= '0;
      rd_cnt     <= '0;
      beat_cnt   <= '0;
      asm_q      <= '0;
      shift_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            n_in_q     <= n_in;
            n_out_q    <= n_out;
            res_base_q <= res_base;
            word_cnt   <= '0;
            rd_cnt     <= '0;
            beat_cnt   <= '0;
          end
        end
        LOAD: begin
          if (in_valid) begin
            asm_q    <= {in_data, asm_q[Data-1:Beat]};
            beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + BEAT_ONE;
          end
        end
        WR: begin
          word_cnt <= word_cnt_inc;
        end
        RD_D: begin
          shift_q  <= a_data_out;
          beat_cnt <= '0;
        end
        STREAM: begin
          if (out_ready) begin
            shift_q <= shift_q >> Beat;
            if (beat_cnt == LAST_BEAT) begin
              beat_cnt <= '0;
              rd_cnt   <= rd_cnt_inc;
            end else begin
              beat_cnt <= beat_cnt + BEAT_ONE;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_scalar_mul_ram_loader.sv
// Scoreboard bench for scalar_mul_ram_loader: a behavioural RAM plays the engine, expected
// RAM writes and result beats are queued by stimulus and checked by a negedge monitor.
module tb_scalar_mul_ram_loader;

  localparam int Data      = 256;
  localparam int Addr      = 5;
  localparam int Beat      = 32;
  localparam int CMD_ADDR  = 62;
  localparam int STAT_ADDR = 63;

  localparam logic [Data-1:0] W0   = 256'h00000008_00000007_00000006_00000005_00000004_00000003_00000002_00000001;
  localparam logic [Data-1:0] W1   = 256'h00000010_0000000f_0000000e_0000000d_0000000c_0000000b_0000000a_00000009;
  localparam logic [Data-1:0] WB   = 256'ha0000007_a0000006_a0000005_a0000004_a0000003_a0000002_a0000001_a0000000;
  localparam logic [Data-1:0] RES4 = 256'h11111111_22222222_33333333_44444444_55555555_66666666_77777777_deadbeef;

  typedef struct {
    logic [Addr:0]   addr;
    logic [Data-1:0] data;
  } wr_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic [Addr:0]   n_in = '0, res_base = '0, n_out = '0;
  logic [Beat-1:0] in_data = '0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [Beat-1:0] out_data;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic            busy, done, a_w;
  logic [Addr:0]   a_adbus;
  logic [Data-1:0] a_data_in;
  logic [Data-1:0] a_data_out = '0;

  logic [Data-1:0] ram [0:63];
  logic            preload_en = 1'b0;
  logic [Addr:0]   preload_addr = '0;
  logic [Data-1:0] preload_data = '0;
  int              poll_cnt = 0;
  int              poll_goal = 0;
  logic            toggle_mode = 1'b0;

  wr_t             exp_wr[$];
  logic [Beat-1:0] exp_beat[$];
  int              n_compared = 0;
  int              n_mismatched = 0;
  int              done_cnt = 0;
  int              beats_seen = 0;

  logic            prev_stall = 1'b0;
  logic [Beat-1:0] prev_data = '0;
  logic            prev_cmd_wr = 1'b0;
  logic            prev_done = 1'b0;

  scalar_mul_ram_loader #(
    .Data(Data), .Addr(Addr), .Beat(Beat), .CMD_ADDR(CMD_ADDR), .STAT_ADDR(STAT_ADDR)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .n_in(n_in), .res_base(res_base), .n_out(n_out),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .a_w(a_w), .a_adbus(a_adbus),
    .a_data_in(a_data_in), .a_data_out(a_data_out)
  );

  always #5 clk = ~clk;

  // Engine model: status bit0 rises once poll_goal status reads have been made
  always @(posedge clk) begin
    if (preload_en) ram[preload_addr] <= preload_data;
    else if (a_w)   ram[a_adbus] <= a_data_in;
    if (!a_w && a_adbus == STAT_ADDR) begin
      a_data_out <= {{(Data-1){1'b0}}, (poll_cnt >= poll_goal)};
      poll_cnt   <= poll_cnt + 1;
    end else begin
      a_data_out <= ram[a_adbus];
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = toggle_mode ? ~out_ready : 1'b1;
    end
  end

  task automatic check_output(input string name, input logic [Data-1:0] act, input logic [Data-1:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    wr_t             w;
    logic [Beat-1:0] b;
    if (a_w) begin
      if (exp_wr.size() == 0) begin
        n_compared++;
        n_mismatched++;
        $display("[TB] FAIL unexpected_write: got addr %0d data %0h expected no write", a_adbus, a_data_in);
      end else begin
        w = exp_wr.pop_front();
        check_output("wr_addr", {{(Data-Addr-1){1'b0}}, a_adbus}, {{(Data-Addr-1){1'b0}}, w.addr});
        check_output("wr_data", a_data_in, w.data);
      end
      if (a_adbus == CMD_ADDR) check_output("cmd_not_back_to_back", {{(Data-1){1'b0}}, prev_cmd_wr}, '0);
    end
    prev_cmd_wr = a_w && (a_adbus == CMD_ADDR);
    if (prev_stall) begin
      check_output("stall_valid_held", {{(Data-1){1'b0}}, out_valid}, 1);
      check_output("stall_data_held", {{(Data-Beat){1'b0}}, out_data}, {{(Data-Beat){1'b0}}, prev_data});
    end
    if (out_valid && out_ready) begin
      beats_seen++;
      if (exp_beat.size() == 0) begin
        n_compared++;
        n_mismatched++;
        $display("[TB] FAIL unexpected_beat: got %0h expected no beat", out_data);
      end else begin
        b = exp_beat.pop_front();
        check_output("out_beat", {{(Data-Beat){1'b0}}, out_data}, {{(Data-Beat){1'b0}}, b});
      end
    end
    prev_stall = out_valid && !out_ready;
    prev_data  = out_data;
    if (done) begin
      done_cnt++;
      check_output("done_one_cycle", {{(Data-1){1'b0}}, prev_done}, '0);
    end
    prev_done = done;
  end

  task automatic preload(input logic [Addr:0] addr, input logic [Data-1:0] data);
    @(posedge clk);
    #1;
    preload_en   = 1'b1;
    preload_addr = addr;
    preload_data = data;
    @(posedge clk);
    #1;
    preload_en = 1'b0;
  endtask

  task automatic apply_stimulus(input int ni, input int no, input int rb, input int zero_polls);
    @(posedge clk);
    #1;
    poll_goal = poll_cnt + zero_polls;
    n_in      = ni[Addr:0];
    n_out     = no[Addr:0];
    res_base  = rb[Addr:0];
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic send_beat(input logic [Beat-1:0] d);
    int cnt = 0;
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    while (!in_ready && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    check_output("in_ready_within_bound", {{(Data-1){1'b0}}, in_ready}, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int max_cycles);
    for (int i = 0; i < max_cycles && done_cnt == d0; i++) @(posedge clk);
    #1;
    check_output("done_count", done_cnt - d0, 1);
    check_output("busy_after_done", {{(Data-1){1'b0}}, busy}, '0);
    check_output("wr_queue_drained", exp_wr.size(), 0);
    check_output("beat_queue_drained", exp_beat.size(), 0);
  endtask

  initial begin
    logic [Beat-1:0] res4_beats [8];
    int d0;
    int p0;
    int bs0;
    int cnt;
    res4_beats = '{32'hdeadbeef, 32'h77777777, 32'h66666666, 32'h55555555,
                   32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_output("rst_busy", {{(Data-1){1'b0}}, busy}, '0);
    check_output("rst_done", {{(Data-1){1'b0}}, done}, '0);
    check_output("rst_in_ready", {{(Data-1){1'b0}}, in_ready}, '0);
    check_output("rst_out_valid", {{(Data-1){1'b0}}, out_valid}, '0);
    check_output("rst_out_data", {{(Data-Beat){1'b0}}, out_data}, '0);
    check_output("rst_a_w", {{(Data-1){1'b0}}, a_w}, '0);
    check_output("rst_a_adbus", {{(Data-Addr-1){1'b0}}, a_adbus}, '0);
    check_output("rst_a_data_in", a_data_in, '0);

    $display("[TB] job A: two operand words, five zero polls, one result word");
    preload(6'd4, RES4);
    exp_wr.push_back('{6'd0, W0});
    exp_wr.push_back('{6'd1, W1});
    exp_wr.push_back('{6'd62, 256'd1});
    exp_wr.push_back('{6'd62, 256'd0});
    for (int i = 0; i < 8; i++) exp_beat.push_back(res4_beats[i]);
    d0 = done_cnt;
    p0 = poll_cnt;
    apply_stimulus(2, 1, 4, 5);
    for (int i = 1; i <= 16; i++) send_beat(i[Beat-1:0]);
    wait_done(d0, 500);
    check_output("poll_count", poll_cnt - p0, 6);
    check_output("ram0_operand", ram[0], W0);
    check_output("ram1_operand", ram[1], W1);
    check_output("ram62_cleared", ram[62], '0);

    $display("[TB] job B: out_ready toggling, result address wraps 63 -> 0");
    toggle_mode = 1'b1;
    exp_wr.push_back('{6'd0, WB});
    exp_wr.push_back('{6'd62, 256'd1});
    exp_wr.push_back('{6'd62, 256'd0});
    exp_beat.push_back(32'h1);
    for (int i = 1; i < 8; i++) exp_beat.push_back(32'h0);
    for (int i = 0; i < 8; i++) exp_beat.push_back(32'ha0000000 + i);
    d0 = done_cnt;
    apply_stimulus(1, 2, 63, 0);
    for (int i = 0; i < 8; i++) send_beat(32'ha0000000 + i);
    wait_done(d0, 500);
    toggle_mode = 1'b0;

    $display("[TB] job C: start pulsed during STREAM is ignored");
    exp_wr.push_back('{6'd62, 256'd1});
    exp_wr.push_back('{6'd62, 256'd0});
    for (int i = 0; i < 8; i++) exp_beat.push_back(res4_beats[i]);
    d0 = done_cnt;
    apply_stimulus(0, 1, 4, 2);
    cnt = 0;
    @(negedge clk);
    while (!out_valid && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    check_output("stream_started", {{(Data-1){1'b0}}, out_valid}, 1);
    @(posedge clk);
    #1;
    n_in = 6'd3;
    n_out = 6'd5;
    res_base = 6'd0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(d0, 500);
    repeat (20) @(posedge clk);
    #1;
    check_output("no_restart_busy", {{(Data-1){1'b0}}, busy}, '0);
    check_output("no_restart_done_count", done_cnt - d0, 1);

    $display("[TB] job D: reset during POLL_D aborts the job");
    exp_wr.push_back('{6'd62, 256'd1});
    apply_stimulus(0, 1, 4, 1000);
    cnt = 0;
    @(negedge clk);
    while (a_adbus != STAT_ADDR && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    check_output("poll_reached", {{(Data-Addr-1){1'b0}}, a_adbus}, STAT_ADDR);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_output("abort_busy", {{(Data-1){1'b0}}, busy}, '0);
    check_output("abort_a_w", {{(Data-1){1'b0}}, a_w}, '0);
    check_output("abort_a_adbus", {{(Data-Addr-1){1'b0}}, a_adbus}, '0);
    check_output("abort_out_valid", {{(Data-1){1'b0}}, out_valid}, '0);
    check_output("abort_wr_queue", exp_wr.size(), 0);
    check_output("abort_cmd_left", ram[62], 256'd1);

    $display("[TB] job E: empty job after abort");
    exp_wr.push_back('{6'd62, 256'd1});
    exp_wr.push_back('{6'd62, 256'd0});
    d0 = done_cnt;
    bs0 = beats_seen;
    apply_stimulus(0, 0, 0, 1);
    wait_done(d0, 500);
    check_output("empty_job_no_beats", beats_seen - bs0, 0);
    check_output("empty_job_cmd_cleared", ram[62], '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  initial begin
    #300000;
    $display("[TB] FAIL global_timeout: got no finish expected finish before 300000");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
